// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key-entry front end.
// Optional auto-repeat of digit keys is enabled with `define KEY_AUTOREPEAT_EN.
package calc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_REM  = 3'd4,
      OP_POW  = 3'd5,
      OP_FACT = 3'd6
   } op_e;

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_ENTER_B = 2'd1,
      ST_DONE    = 2'd2,
      ST_ERR     = 2'd3
   } state_e;

   typedef struct packed {
      logic vld;
      op_e  op;
   } op_sel_t;

   localparam int unsigned NUM_KEYS  = 12;
   localparam logic [3:0]  KEY_CLEAR = 4'd10;
   localparam logic [3:0]  KEY_ENTER = 4'd11;

   localparam logic [7:0] ASCII_BLANK = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_ADD   = 8'h2B;
   localparam logic [7:0] ASCII_SUB   = 8'h2D;
   localparam logic [7:0] ASCII_MUL   = 8'hD7;
   localparam logic [7:0] ASCII_DIV   = 8'h2F;
   localparam logic [7:0] ASCII_REM   = 8'hF7;
   localparam logic [7:0] ASCII_POW   = 8'h5E;
   localparam logic [7:0] ASCII_FACT  = 8'h21;

   function automatic logic [7:0] op_char(input op_e op);
      case (op)
         OP_ADD:  op_char = ASCII_ADD;
         OP_SUB:  op_char = ASCII_SUB;
         OP_MUL:  op_char = ASCII_MUL;
         OP_DIV:  op_char = ASCII_DIV;
         OP_REM:  op_char = ASCII_REM;
         OP_POW:  op_char = ASCII_POW;
         OP_FACT: op_char = ASCII_FACT;
         default: op_char = ASCII_BLANK;
      endcase
   endfunction

   // Lowest set switch wins; bit 7 is not an operator.
   function automatic op_sel_t sel_op(input logic [6:0] dip);
      sel_op.vld = 1'b0;
      sel_op.op  = OP_ADD;
      for (int i = 6; i >= 0; i--) begin
         if (dip[i]) begin
            sel_op.vld = 1'b1;
            sel_op.op  = op_e'(3'(i));
         end
      end
   endfunction

   // {tens, units} characters; an empty units slot reads '0' once the operand is closed.
   function automatic logic [15:0] enc_operand(input logic [6:0] val,
                                               input logic [1:0] nd,
                                               input logic       closed);
      logic [6:0] tens;
      logic [6:0] units;
      tens  = val / 7'd10;
      units = val % 7'd10;
      case (nd)
         2'd0:    enc_operand = {ASCII_BLANK, closed ? ASCII_ZERO : ASCII_BLANK};
         2'd1:    enc_operand = {ASCII_BLANK, ASCII_ZERO + {1'b0, units}};
         default: enc_operand = {ASCII_ZERO + {1'b0, tens}, ASCII_ZERO + {1'b0, units}};
      endcase
   endfunction

endpackage

// File: rtl/calc_key_entry_debounce.sv
// Single-key debouncer: registered one-cycle press event, re-armed by a low sample.
// With `define KEY_AUTOREPEAT_EN a held key also emits delayed repeat events.
module key_debounce #(
   parameter int unsigned DEBOUNCE_TICKS = 3
`ifdef KEY_AUTOREPEAT_EN
   , parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 20,
   parameter bit          REPEAT_EN    = 1'b1
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic key_in,
   output logic press
);

   localparam int unsigned    CW      = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_TICKS);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic          fire;

   // armed_q starts low so a key held through reset cannot fire until released.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      fire    = 1'b0;
      if (sample_en) begin
         if (key_in) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
               fire  = armed_q && (cnt_q == CNT_MAX - 1'b1);
            end
         end else begin
            cnt_d   = '0;
            armed_d = 1'b1;
         end
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned   RMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned   RW        = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_first_q, rpt_first_d;
   logic [RW-1:0] rpt_limit;
   logic          rpt_fire;

   always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      rpt_fire    = 1'b0;
      rpt_limit   = rpt_first_q ? RPT_RATE : RPT_DELAY;
      if (sample_en) begin
         if (!key_in) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
         end else if (REPEAT_EN && armed_q && (cnt_q == CNT_MAX)) begin
            if (rpt_cnt_q + 1'b1 == rpt_limit) begin
               rpt_fire    = 1'b1;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end

   assign press_d = fire | rpt_fire;
`else
   assign press_d = fire;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/calc_key_entry.sv
// Calculator key entry: debounced keys -> two 2-digit operands, operator, ASCII view.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat on held digit keys.
module calc_key_entry
   import calc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 3,
   parameter int unsigned REPEAT_DELAY   = 50,
   parameter int unsigned REPEAT_RATE    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_en,
   input  logic [11:0] sw,
   input  logic [7:0]  dipsw,
   output logic [6:0]  opa,
   output logic [6:0]  opb,
   output logic [2:0]  op_code,
   output logic [15:0] opa_ascii,
   output logic [15:0] opb_ascii,
   output logic [7:0]  op_ascii,
   output logic        result_req,
   output logic [3:0]  led
);

   logic [NUM_KEYS-1:0] press;
   logic                unused_dip;

   assign unused_dip = dipsw[7];

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef KEY_AUTOREPEAT_EN
         , .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE),
         .REPEAT_EN   (i < int'(KEY_CLEAR))
`endif
      ) u_key (
         .clk      (clk),
         .rst      (rst),
         .sample_en(sample_en),
         .key_in   (sw[i]),
         .press    (press[i])
      );
   end

   logic       key_vld;
   logic [3:0] key_idx;

   // Lowest index wins; the losers stay saturated and do not re-fire while held.
   always_comb begin
      key_vld = 1'b0;
      key_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) begin
            key_vld = 1'b1;
            key_idx = 4'(i);
         end
      end
   end

   state_e      state_q, state_d;
   logic [6:0]  opa_q, opa_d, opb_q, opb_d;
   logic [1:0]  nd_a_q, nd_a_d, nd_b_q, nd_b_d;
   logic        closed_a_q, closed_a_d, closed_b_q, closed_b_d;
   op_e         op_q, op_d;
   logic        op_vld_q, op_vld_d;
   logic [15:0] opa_ascii_q, opa_ascii_d, opb_ascii_q, opb_ascii_d;
   logic [7:0]  op_ascii_q, op_ascii_d;
   logic        result_req_q, result_req_d;
   logic [3:0]  led_q, led_d;
   op_sel_t     sel;
   logic [6:0]  digit;

   assign sel   = sel_op(dipsw[6:0]);
   assign digit = {3'b000, key_idx};

   always_comb begin
      state_d    = state_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      nd_a_d     = nd_a_q;
      nd_b_d     = nd_b_q;
      closed_a_d = closed_a_q;
      closed_b_d = closed_b_q;
      op_d       = op_q;
      op_vld_d   = op_vld_q;
      if (key_vld) begin
         if (key_idx == KEY_CLEAR) begin
            state_d    = ST_ENTER_A;
            opa_d      = '0;
            opb_d      = '0;
            nd_a_d     = '0;
            nd_b_d     = '0;
            closed_a_d = 1'b0;
            closed_b_d = 1'b0;
            op_d       = OP_ADD;
            op_vld_d   = 1'b0;
         end else if (key_idx == KEY_ENTER) begin
            case (state_q)
               ST_ENTER_A: begin
                  closed_a_d = 1'b1;
                  if (!sel.vld) begin
                     state_d = ST_ERR;
                  end else begin
                     op_d     = sel.op;
                     op_vld_d = 1'b1;
                     state_d  = (sel.op == OP_FACT) ? ST_DONE : ST_ENTER_B;
                  end
               end
               ST_ENTER_B: begin
                  closed_b_d = 1'b1;
                  state_d    = ST_DONE;
               end
               default: ;
            endcase
         end else begin
            case (state_q)
               ST_ENTER_A: begin
                  if (nd_a_q != 2'd2) begin
                     opa_d  = opa_q * 7'd10 + digit;
                     nd_a_d = nd_a_q + 1'b1;
                  end
               end
               ST_ENTER_B: begin
                  if (nd_b_q != 2'd2) begin
                     opb_d  = opb_q * 7'd10 + digit;
                     nd_b_d = nd_b_q + 1'b1;
                  end
               end
               default: begin
                  // A digit after a finished or failed expression starts a new one.
                  state_d    = ST_ENTER_A;
                  opa_d      = digit;
                  nd_a_d     = 2'd1;
                  opb_d      = '0;
                  nd_b_d     = '0;
                  closed_a_d = 1'b0;
                  closed_b_d = 1'b0;
               end
            endcase
         end
      end

      result_req_d = (state_d == ST_DONE) && (state_q != ST_DONE);
      case (state_d)
         ST_ENTER_A: led_d = 4'b0001;
         ST_ENTER_B: led_d = 4'b0010;
         ST_DONE:    led_d = 4'b0100;
         default:    led_d = 4'b1000;
      endcase
      opa_ascii_d = enc_operand(opa_d, nd_a_d, closed_a_d);
      opb_ascii_d = enc_operand(opb_d, nd_b_d, closed_b_d);
      op_ascii_d  = op_vld_d ? op_char(op_d) : ASCII_BLANK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_ENTER_A;
         opa_q        <= '0;
         opb_q        <= '0;
         nd_a_q       <= '0;
         nd_b_q       <= '0;
         closed_a_q   <= 1'b0;
         closed_b_q   <= 1'b0;
         op_q         <= OP_ADD;
         op_vld_q     <= 1'b0;
         opa_ascii_q  <= {ASCII_BLANK, ASCII_BLANK};
         opb_ascii_q  <= {ASCII_BLANK, ASCII_BLANK};
         op_ascii_q   <= ASCII_BLANK;
         result_req_q <= 1'b0;
         led_q        <= 4'b0001;
      end else begin
         state_q      <= state_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         nd_a_q       <= nd_a_d;
         nd_b_q       <= nd_b_d;
         closed_a_q   <= closed_a_d;
         closed_b_q   <= closed_b_d;
         op_q         <= op_d;
         op_vld_q     <= op_vld_d;
         opa_ascii_q  <= opa_ascii_d;
         opb_ascii_q  <= opb_ascii_d;
         op_ascii_q   <= op_ascii_d;
         result_req_q <= result_req_d;
         led_q        <= led_d;
      end
   end

   assign opa        = opa_q;
   assign opb        = opb_q;
   assign op_code    = op_q;
   assign opa_ascii  = opa_ascii_q;
   assign opb_ascii  = opb_ascii_q;
   assign op_ascii   = op_ascii_q;
   assign result_req = result_req_q;
   assign led        = led_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: keystroke-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_calc_key_entry;

   localparam int DT = 3;
   localparam int RD = 50;
   localparam int RR = 20;

   logic        clk;
   logic        rst;
   logic        sample_en;
   logic [11:0] sw;
   logic [7:0]  dipsw;
   logic [6:0]  opa, opb;
   logic [2:0]  op_code;
   logic [15:0] opa_ascii, opb_ascii;
   logic [7:0]  op_ascii;
   logic        result_req;
   logic [3:0]  led;

   calc_key_entry dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .sw        (sw),
      .dipsw     (dipsw),
      .opa       (opa),
      .opb       (opb),
      .op_code   (op_code),
      .opa_ascii (opa_ascii),
      .opb_ascii (opb_ascii),
      .op_ascii  (op_ascii),
      .result_req(result_req),
      .led       (led)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] op_chars [7] = '{8'h2B, 8'h2D, 8'hD7, 8'h2F, 8'hF7, 8'h5E, 8'h21};
   int  held [12];
   bit  seen_low [12];
   int  pend;
   int  a_dig[$], b_dig[$];
   bit  a_closed, b_closed, m_op_vld, m_req;
   int  m_op, m_state;   // m_state: 0 A, 1 B, 2 DONE, 3 ERR

   task automatic model_reset();
      for (int k = 0; k < 12; k++) begin
         held[k] = 0;
         seen_low[k] = 1'b0;
      end
      pend = -1;
      a_dig.delete();
      b_dig.delete();
      a_closed = 0; b_closed = 0; m_op_vld = 0; m_req = 0;
      m_op = 0; m_state = 0;
   endtask

   function automatic bit key_fires(int k);
      if (!seen_low[k]) return 1'b0;
      if (held[k] == DT) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
      if (k < 10 && held[k] > DT) begin
         int x = held[k] - DT;
         if (x == RD) return 1'b1;
         if (x > RD && ((x - RD) % RR) == 0) return 1'b1;
      end
`endif
      return 1'b0;
   endfunction

   task automatic apply_key(input int k);
      int prev = m_state;
      if (k == 10) begin
         a_dig.delete(); b_dig.delete();
         a_closed = 0; b_closed = 0; m_op = 0; m_op_vld = 0; m_state = 0;
      end else if (k == 11) begin
         if (m_state == 0) begin
            int found = -1;
            for (int i = 6; i >= 0; i--) if (dipsw[i]) found = i;
            a_closed = 1;
            if (found < 0) m_state = 3;
            else begin
               m_op = found; m_op_vld = 1;
               m_state = (found == 6) ? 2 : 1;
            end
         end else if (m_state == 1) begin
            b_closed = 1;
            m_state = 2;
         end
      end else begin
         if (m_state == 0) begin
            if (a_dig.size() < 2) a_dig.push_back(k);
         end else if (m_state == 1) begin
            if (b_dig.size() < 2) b_dig.push_back(k);
         end else begin
            a_dig.delete(); b_dig.delete();
            a_dig.push_back(k);
            a_closed = 0; b_closed = 0; m_state = 0;
         end
      end
      m_req = (m_state == 2) && (prev != 2);
   endtask

   // One posedge of model time: the event seen last edge reaches the outputs now.
   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      m_req = 0;
      if (pend >= 0) apply_key(pend);
      pend = -1;
      if (sample_en) begin
         for (int k = 0; k < 12; k++) begin
            if (sw[k]) begin
               held[k]++;
               if (key_fires(k) && pend < 0) pend = k;
            end else begin
               held[k] = 0;
               seen_low[k] = 1'b1;
            end
         end
      end
   endtask

   function automatic int dig_val(int n, int d0, int d1);
      if (n >= 2) return 10 * d0 + d1;
      if (n == 1) return d0;
      return 0;
   endfunction

   function automatic logic [15:0] dig_ascii(int n, int d0, int d1, bit closed);
      logic [7:0] c0, c1;
      c0 = 8'h30 + 8'(d0);
      c1 = 8'h30 + 8'(d1);
      if (n >= 2) return {c0, c1};
      if (n == 1) return {8'h20, c0};
      return {8'h20, closed ? 8'h30 : 8'h20};
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         int na, nb, a0, a1, b0, b1;
         na = a_dig.size(); nb = b_dig.size();
         a0 = (na > 0) ? a_dig[0] : 0; a1 = (na > 1) ? a_dig[1] : 0;
         b0 = (nb > 0) ? b_dig[0] : 0; b1 = (nb > 1) ? b_dig[1] : 0;
         check("opa", int'(opa), dig_val(na, a0, a1));
         check("opb", int'(opb), dig_val(nb, b0, b1));
         check("op_code", int'(op_code), m_op);
         check("opa_ascii", int'(opa_ascii), int'(dig_ascii(na, a0, a1, a_closed)));
         check("opb_ascii", int'(opb_ascii), int'(dig_ascii(nb, b0, b1, b_closed)));
         check("op_ascii", int'(op_ascii), m_op_vld ? int'(op_chars[m_op]) : 32'h20);
         check("result_req", int'(result_req), int'(m_req));
         check("led", int'(led), 1 << m_state);
         if (result_req) pulses++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input bit se);
      sample_en = se;
      @(posedge clk);
      model_step();
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   task automatic strobe();
      cyc(1'b1);
      cyc(1'b0);
   endtask

   task automatic press(input int k);
      sw[k] = 1'b1;
      repeat (DT) strobe();
      sw[k] = 1'b0;
      strobe();
      repeat (2) cyc(1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) cyc(1'b0);
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_opa"}, int'(opa), 0);
      check({tag, "_opb"}, int'(opb), 0);
      check({tag, "_op_code"}, int'(op_code), 0);
      check({tag, "_opa_ascii"}, int'(opa_ascii), 32'h2020);
      check({tag, "_opb_ascii"}, int'(opb_ascii), 32'h2020);
      check({tag, "_op_ascii"}, int'(op_ascii), 32'h20);
      check({tag, "_req"}, int'(result_req), 0);
      check({tag, "_led"}, int'(led), 4'b0001);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; sample_en = 1'b0; sw = '0; dipsw = '0;
      model_reset();
      @(negedge clk);
      do_reset();
      chk_en = 1'b1;
      check_reset_vals("reset");
      strobe();

      // 42 + 7
      pulses = 0;
      press(4); press(2);
      dipsw = 8'h01;
      press(11);
      press(7);
      press(11);
      check("t1_opa", int'(opa), 42);
      check("t1_opb", int'(opb), 7);
      check("t1_op_code", int'(op_code), 0);
      check("t1_opa_ascii", int'(opa_ascii), 32'h3432);
      check("t1_op_ascii", int'(op_ascii), 32'h2B);
      check("t1_opb_ascii", int'(opb_ascii), 32'h2037);
      check("t1_led", int'(led), 4'b0100);
      check("t1_pulses", pulses, 1);

      // Short press is rejected, long press yields one digit
      press(10);
      sw[3] = 1'b1;
      repeat (2) strobe();
      sw[3] = 1'b0;
      strobe(); repeat (2) cyc(1'b0);
      check("t2_short_opa", int'(opa), 0);
      sw[3] = 1'b1;
      repeat (5) strobe();
      sw[3] = 1'b0;
      strobe(); repeat (2) cyc(1'b0);
      check("t2_long_opa", int'(opa), 3);
      check("t2_long_ascii", int'(opa_ascii), 32'h2033);

      // Third digit ignored, ENTER without operator -> error
      press(10);
      press(1); press(2); press(3);
      check("t3_opa", int'(opa), 12);
      check("t3_opa_ascii", int'(opa_ascii), 32'h3132);
      dipsw = 8'h00;
      pulses = 0;
      press(11);
      check("t3_led", int'(led), 4'b1000);
      check("t3_pulses", pulses, 0);

      // Simultaneous press: lowest index only, loser waits for release
      press(10);
      sw[5] = 1'b1; sw[2] = 1'b1;
      repeat (DT) strobe();
      sw[2] = 1'b0;
      repeat (3) strobe();
      repeat (2) cyc(1'b0);
      check("t4_opa", int'(opa), 2);
      sw[5] = 1'b0;
      strobe();
      press(5);
      check("t4_opa_again", int'(opa), 25);

      // Factorial goes straight to DONE; next digit starts a new expression
      press(10);
      press(5);
      dipsw = 8'h40;
      pulses = 0;
      press(11);
      check("t5_op_ascii", int'(op_ascii), 32'h21);
      check("t5_op_code", int'(op_code), 6);
      check("t5_opa_ascii", int'(opa_ascii), 32'h2035);
      check("t5_led", int'(led), 4'b0100);
      check("t5_pulses", pulses, 1);
      dipsw = 8'h01;
      press(9);
      check("t5_new_opa", int'(opa), 9);
      check("t5_new_opb", int'(opb), 0);
      check("t5_new_led", int'(led), 4'b0001);
      check("t5_op_code_held", int'(op_code), 6);

      // Long hold of a digit, then reset while it is still held
      press(10);
      sw[1] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
      repeat (DT + RD + 2 * RR) strobe();
      repeat (2) cyc(1'b0);
      check("t6_repeat_opa", int'(opa), 11);
`else
      repeat (60) strobe();
      repeat (2) cyc(1'b0);
      check("t6_hold_opa", int'(opa), 1);
`endif
      do_reset();
      check_reset_vals("t6_rst");
      repeat (60) strobe();
      repeat (2) cyc(1'b0);
      check("t6_held_after_rst", int'(opa), 0);
      sw[1] = 1'b0;
      strobe();
      press(1);
      check("t6_after_release", int'(opa), 1);

      repeat (4) cyc(1'b0);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
